// File: rtl/npem_status_register.sv
// NPEM command-completion tracker and NPEM Status register read path.
// Each Control-register write opens a command that completes on an enclosure
// acknowledge or on timeout. Completion sets the RW1C Command Completed bit
// and raises a single-outstanding interrupt request.
module npem_status_register #(
  parameter int REGISTER_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REGISTER_WIDTH-1:0] capability_register,
  input  logic                      ctrl_write,
  input  logic                      enclosure_ack,
  input  logic                      int_enable,
  input  logic [7:0]                enclosure_specific_status,
  input  logic                      status_write_enable,
  input  logic [REGISTER_WIDTH-1:0] status_write_data,
  output logic [REGISTER_WIDTH-1:0] read_data,
  output logic                      cmd_busy,
  output logic                      int_req,
  input  logic                      int_ack
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [0:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_cmd_completed;
  logic             r_int_req;

  logic w_capable;
  logic w_timeout;
  logic w_complete;
  logic w_clear;
  logic w_unused;

  assign w_capable  = capability_register[0];
  assign w_timeout  = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign w_complete = w_capable && (r_state == ST_PENDING) && (enclosure_ack || w_timeout);
  assign w_clear    = status_write_enable && status_write_data[0];
  assign w_unused   = ^{capability_register[REGISTER_WIDTH-1:1],
                        status_write_data[REGISTER_WIDTH-1:1]};

  // Command tracking FSM and timeout counter; a new command always restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (!w_capable) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (ctrl_write) begin
      r_state <= ST_PENDING;
      r_cnt   <= '0;
    end else if (r_state == ST_PENDING) begin
      if (w_complete) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // RW1C Command Completed bit; a set event takes priority over a software clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd_completed <= 1'b0;
    end else if (w_complete) begin
      r_cmd_completed <= 1'b1;
    end else if (w_clear) begin
      r_cmd_completed <= 1'b0;
    end
  end

  // Level interrupt request: set on enabled completion, cleared by the consumer's ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_req <= 1'b0;
    end else if (w_complete && int_enable) begin
      r_int_req <= 1'b1;
    end else if (int_ack) begin
      r_int_req <= 1'b0;
    end
  end

  // Status register read value; all zero when the function is not NPEM capable.
  always_comb begin
    read_data = '0;
    if (w_capable) begin
      read_data = {enclosure_specific_status, {(REGISTER_WIDTH-9){1'b0}}, r_cmd_completed};
    end
  end

  assign cmd_busy = (r_state == ST_PENDING);
  assign int_req  = r_int_req;

endmodule
